// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared encodings and constants
// for the instruction fetch stage.
package ifetch_pkg;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JAL  = 2'b10;
    localparam logic [1:0] NPC_JALR = 2'b11;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_TRAP
    } state_t;

endpackage

// File: rtl/ifetch_npc.sv
// ifetch_npc: combinational next-PC calculator
// driven by the decode/execute redirect controls.
module ifetch_npc
    import ifetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] sext,
    input  logic [31:0] alu_c,
    output logic [31:0] npc
);

    logic [31:0] seq;
    logic [31:0] rel;

    assign seq = pc + 32'd4;
    assign rel = pc + sext;

    // select the redirect target; jalr drops bit 0
    always_comb begin
        npc = seq;
        case (npc_op)
            NPC_PC4:  npc = seq;
            NPC_BR:   npc = br_taken ? rel : seq;
            NPC_JAL:  npc = rel;
            NPC_JALR: npc = alu_c & ~32'h1;
            default:  npc = seq;
        endcase
    end

endmodule

// File: rtl/ifetch.sv
// ifetch: owns the PC, fetches one instruction at a time
// and holds it stable until decode accepts it.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = ifetch_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] sext,
    input  logic [31:0] alu_c,
    input  logic        id_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        inst_valid,
    output logic        misalign,
    output logic [31:0] instret
);

    import ifetch_pkg::*;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] instret_q;
    logic        misalign_q;
    logic [31:0] npc_val;
    logic        accept;
    logic        aligned;

    assign accept  = (state == S_HOLD) && id_ready;
    assign aligned = (npc_val[1:0] == 2'b00);

    ifetch_npc u_npc (
        .pc       (pc_q),
        .npc_op   (npc_op),
        .br_taken (br_taken),
        .sext     (sext),
        .alu_c    (alu_c),
        .npc      (npc_val)
    );

    // state register; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state and state-decoded strobes
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                imem_req   = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                inst_valid = 1'b1;
                if (id_ready) begin
                    state_next = aligned ? S_REQ : S_TRAP;
                end
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // pc, held instruction, retire count and sticky trap flag
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc_q       <= RESET_PC;
            inst_q     <= NOP_INST;
            instret_q  <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            if (state == S_WAIT && imem_rvalid) begin
                inst_q <= imem_rdata;
            end
            if (accept) begin
                inst_q    <= NOP_INST;
                instret_q <= instret_q + 32'd1;
                if (aligned) begin
                    pc_q <= npc_val;
                end else begin
                    misalign_q <= 1'b1;
                end
            end
        end
    end

    assign pc        = pc_q;
    assign pc4       = pc_q + 32'd4;
    assign imem_addr = pc_q;
    assign inst      = inst_q;
    assign instret   = instret_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed and randomized checks of ifetch
// against a transaction-level model of the fetch stage.
module tb_ifetch;

    import ifetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  npc_op = 2'b00;
    logic        br_taken = 1'b0;
    logic [31:0] sext = 32'h0;
    logic [31:0] alu_c = 32'h0;
    logic        id_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        inst_valid;
    logic        misalign;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic        m_mis;

    ifetch #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .npc_op      (npc_op),
        .br_taken    (br_taken),
        .sext        (sext),
        .alu_c       (alu_c),
        .id_ready    (id_ready),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .pc          (pc),
        .pc4         (pc4),
        .inst_valid  (inst_valid),
        .misalign    (misalign),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // architectural next-PC rule written from the ISA view
    function automatic logic [31:0] ref_npc(input logic [31:0] p,
                                            input logic [1:0] op,
                                            input logic br,
                                            input logic [31:0] sx,
                                            input logic [31:0] ac);
        if (op == 2'd3) return {ac[31:1], 1'b0};
        if (op == 2'd2 || (op == 2'd1 && br)) return p + sx;
        return p + 32'd4;
    endfunction

    task automatic do_reset;
        rst_n = 1'b1;
        imem_rvalid = 1'b0;
        id_ready = 1'b0;
        tick;
        tick;
        m_pc = RST_PC;
        m_instret = 32'd0;
        m_mis = 1'b0;
        chk("rst_pc", pc, RST_PC);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_pc4", pc4, RST_PC + 32'd4);
        chk("rst_inst", inst, NOP);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        rst_n = 1'b0;
    endtask

    // one instruction: request, memory reply, hold/stall, accept
    task automatic fetch(input int dly, input int stall,
                         input logic [1:0] op, input logic br,
                         input logic [31:0] sx, input logic [31:0] ac,
                         input logic [31:0] word, output int req_cyc);
        int n;
        logic [31:0] nx;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        chk("req_seen", {31'd0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, m_pc);
        chk("req_valid", {31'd0, inst_valid}, 32'd0);
        req_cyc = cyc;
        tick;
        for (int i = 0; i < dly; i++) begin
            chk("wait_req", {31'd0, imem_req}, 32'd0);
            chk("wait_inst", inst, NOP);
            tick;
        end
        imem_rvalid = 1'b1;
        imem_rdata = word;
        tick;
        imem_rvalid = 1'b0;
        imem_rdata = $urandom;
        for (int i = 0; i <= stall; i++) begin
            chk("hold_valid", {31'd0, inst_valid}, 32'd1);
            chk("hold_inst", inst, word);
            chk("hold_pc", pc, m_pc);
            chk("hold_pc4", pc4, m_pc + 32'd4);
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            if (i < stall) begin
                imem_rvalid = 1'($urandom_range(0, 1));
                imem_rdata = 32'hDEAD_BEEF;
                tick;
                imem_rvalid = 1'b0;
            end
        end
        npc_op = op;
        br_taken = br;
        sext = sx;
        alu_c = ac;
        id_ready = 1'b1;
        tick;
        id_ready = 1'b0;
        npc_op = 2'($urandom);
        br_taken = 1'($urandom);
        nx = ref_npc(m_pc, op, br, sx, ac);
        m_instret = m_instret + 32'd1;
        if (nx % 4 == 0) m_pc = nx;
        else m_mis = 1'b1;
        chk("acc_instret", instret, m_instret);
        chk("acc_mis", {31'd0, misalign}, {31'd0, m_mis});
        chk("acc_pc", pc, m_pc);
        chk("acc_inst", inst, NOP);
        chk("acc_req", {31'd0, imem_req}, {31'd0, !m_mis});
        chk("acc_valid", {31'd0, inst_valid}, 32'd0);
    endtask

    initial begin
        int c0, c1, c2, cx;
        logic [31:0] r;

        // sequential fetch at full rate
        do_reset;
        tick;
        chk("first_req", {31'd0, imem_req}, 32'd1);
        fetch(0, 0, NPC_PC4, 1'b0, 32'h0, 32'h0, 32'h0000_0093, c0);
        fetch(0, 0, NPC_PC4, 1'b0, 32'h0, 32'h0, 32'h0000_0113, c1);
        fetch(0, 0, NPC_PC4, 1'b0, 32'h0, 32'h0, 32'h0000_0193, c2);
        chk("period_1", c1 - c0, 32'd3);
        chk("period_2", c2 - c1, 32'd3);
        chk("seq_pc", pc, 32'h0000_000C);
        chk("seq_instret", instret, 32'd3);

        // branch taken / not taken from 0x100
        fetch(0, 0, NPC_JAL, 1'b0, 32'h0000_00F4, 32'h0, 32'h0F40_006F, cx);
        chk("jal_addr", imem_addr, 32'h0000_0100);
        fetch(0, 0, NPC_BR, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'hFE00_08E3, cx);
        chk("br_t_addr", imem_addr, 32'h0000_00F0);
        fetch(1, 0, NPC_JAL, 1'b0, 32'h0000_0010, 32'h0, 32'h0100_006F, cx);
        fetch(0, 1, NPC_BR, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'hFE00_08E3, cx);
        chk("br_nt_addr", imem_addr, 32'h0000_0104);

        // slow memory with decode stalls
        fetch(4, 4, NPC_PC4, 1'b0, 32'h0, 32'h0, 32'h1234_5678, cx);

        // wrap past the top of the address space
        fetch(0, 0, NPC_JALR, 1'b0, 32'h0, 32'hFFFF_FFFD, 32'h0000_8067, cx);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(0, 0, NPC_PC4, 1'b0, 32'h0, 32'h0, 32'h0000_0013, cx);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // random aligned traffic
        for (int k = 0; k < 40; k++) begin
            logic [1:0] op;
            logic [31:0] sx, ac;
            op = 2'($urandom_range(0, 3));
            r = $urandom;
            sx = r & ~32'h3;
            r = $urandom;
            ac = r & ~32'h2;
            fetch($urandom_range(0, 3), $urandom_range(0, 3), op,
                  1'($urandom), sx, ac, $urandom, cx);
        end

        // misaligned jalr traps until reset
        fetch(0, 0, NPC_JALR, 1'b0, 32'h0, 32'h0000_2003, 32'h0000_8067, cx);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("trap_req", {31'd0, imem_req}, 32'd0);
            chk("trap_valid", {31'd0, inst_valid}, 32'd0);
            chk("trap_pc", pc, m_pc);
            chk("trap_mis", {31'd0, misalign}, 32'd1);
        end

        // reset during WAIT, then a late response
        do_reset;
        tick;
        chk("rw_req", {31'd0, imem_req}, 32'd1);
        tick;
        rst_n = 1'b1;
        tick;
        rst_n = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick;
        imem_rvalid = 1'b0;
        chk("rw_inst", inst, NOP);
        chk("rw_valid", {31'd0, inst_valid}, 32'd0);
        chk("rw_req2", {31'd0, imem_req}, 32'd1);
        chk("rw_addr", imem_addr, RST_PC);
        fetch(0, 0, NPC_PC4, 1'b0, 32'h0, 32'h0, 32'h0040_0093, cx);
        chk("rw_next", imem_addr, RST_PC + 32'd4);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage of the single-cycle RISC-V core, directly upstream of the decode stage. It owns the program counter and issues requests to instruction memory through a variable-latency request/response port. It holds each fetched instruction stable until decode accepts it, then computes the next PC from the decode/execute redirect controls, so the decode stage always sees one stable `inst`/`pc` pair per retired instruction.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded by reset.
- `NOP_INST`, 32'h0000_0013, value of `inst` whenever no valid instruction is held (`addi x0,x0,0`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-high (1 = reset).
- `npc_op`  in  2  next-PC select, sampled on accept: 00 pc+4, 01 branch, 10 jal, 11 jalr.
- `br_taken`  in  1  branch comparison result; used only when `npc_op`=01.
- `sext`  in  32  sign-extended immediate from decode (branch/jal offset).
- `alu_c`  in  32  ALU result (jalr target).
- `id_ready`  in  1  decode/execute completes the held instruction this cycle.
- `imem_req`  out  1  one-cycle fetch request strobe.
- `imem_addr`  out  32  fetch address (= `pc`).
- `imem_rvalid`  in  1  instruction memory response valid.
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`.
- `inst`  out  32  held instruction to decode.
- `pc`  out  32  address of `inst`.
- `pc4`  out  32  `pc`+4, for link write-back.
- `inst_valid`  out  1  `inst`/`pc` valid for decode.
- `misalign`  out  1  sticky: redirect target not 4-byte aligned.
- `instret`  out  32  count of accepted instructions.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, TRAP.
- IDLE: entered on reset. Next cycle goes to REQ.
- REQ: `imem_req`=1 for exactly one cycle, `imem_addr`=`pc`. Then goes to WAIT.
- WAIT: when `imem_rvalid`=1, captures `imem_rdata` into `inst` and goes to HOLD. Otherwise stays in WAIT with no timeout.
- HOLD: `inst_valid`=1. `inst` and `pc` are held stable. When `id_ready`=1 (accept), the block computes npc:
  - 00: pc+4.
  - 01: `br_taken` ? pc+`sext` : pc+4.
  - 10: pc+`sext`.
  - 11: `alu_c` & ~32'h1.
- On accept with npc[1:0]==0: `pc`<=npc, `instret`+=1, go to REQ.
- On accept with npc[1:0]!=0: `instret`+=1, `misalign`<=1, `pc` is unchanged, go to TRAP.
- TRAP: `inst_valid`=0 and `imem_req`=0. Only reset leaves TRAP.
- `imem_rvalid` outside WAIT is ignored. At most one request is outstanding.
- Arithmetic is 32-bit modulo 2^32; pc+4 from 32'hFFFF_FFFC wraps to 0. `instret` wraps to 0.
- `inst`=`NOP_INST` whenever `inst_valid`=0.

## Timing
- Reset values: `pc`=`imem_addr`=`RESET_PC`, `pc4`=`RESET_PC`+4, `inst`=`NOP_INST`, `inst_valid`=0, `imem_req`=0, `misalign`=0, `instret`=0, state IDLE.
- Reset dominates any simultaneous event. Asserting reset during WAIT abandons the outstanding request, and a late `imem_rvalid` after reset is ignored, since the FSM is not in WAIT.
- `imem_rvalid` is returned at least 1 cycle after `imem_req`.
- Minimum per-instruction period is 3 cycles: REQ, WAIT (rvalid), HOLD (`id_ready`).
- Latency from reset deassertion to first `inst_valid`=1 is 4 cycles with zero-wait memory.
- `id_ready`=0 in HOLD stalls indefinitely with all outputs stable.
- `pc4` is combinational from `pc`. All other outputs are registered or are state decodes.

## Structure
- Package `ifetch_pkg`:
  - `npc_op` encodings `NPC_PC4`/`NPC_BR`/`NPC_JAL`/`NPC_JALR`.
  - FSM state typedef.
  - `NOP_INST` constant.
- Sub-module `npc`: combinational next-PC calculator with inputs `pc`, `npc_op`, `br_taken`, `sext`, `alu_c` and output npc.

## Test plan
- Reset with `RESET_PC`=0 and memory answering 1 cycle after each request, `npc_op`=00, `id_ready`=1 -> fetch addresses 0,4,8 on consecutive 3-cycle periods; `instret`=3 after third accept.
- In HOLD at pc=0x100, `npc_op`=01 with `br_taken`=1 and `sext`=0xFFFF_FFF0 -> next `imem_addr`=0xF0. Repeating with `br_taken`=0 -> 0x104.
- `npc_op`=11 with `alu_c`=0x0000_2003 -> next pc=0x2002 is misaligned -> `misalign`=1, `inst_valid`=0, `pc` stays, no further `imem_req` until reset.
- `imem_rvalid` delayed 5 cycles with `id_ready`=0 for 4 cycles in HOLD -> `inst`/`pc` stable throughout, exactly one `imem_req` per instruction.
- pc=0xFFFF_FFFC, `npc_op`=00 -> next fetch at 0x0000_0000.
- Reset asserted in WAIT followed by stray `imem_rvalid` (rdata 0xDEAD_BEEF) -> `inst`=0x0000_0013, first new fetch at `RESET_PC`.
